div_issue_ctrl: RTL and testbench

//  RV32M divide front-end between ALU dispatch and the iterative int_div datapath.

---
 rtl/div_pkg.sv | 8 +
 rtl/div_special_case.sv | 18 +
 rtl/div_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, FSM states and special-case result constants for the divide front-end
package div_pkg;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_special_case.sv
// div_special_case: resolves divide-by-zero and signed overflow without the divider
//   op, a, b       : request opcode (bit1 = remainder, bit0 = unsigned), dividend, divisor
//   is_special     : result is known without running the divider
//   special_result : that result (b==0 wins over overflow)
import div_pkg::*;
module div_special_case (
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_result
);
  logic zero, ovf;
  assign zero = b == '0;
  assign ovf = !op[0] && a == INT_MIN && b == NEG_ONE;
  assign is_special = zero || ovf;
  assign special_result = zero ? (op[1] ? a : DIV_ZERO_Q) : (op[1] ? '0 : INT_MIN);
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: RV32M divide front-end between dispatch and an iterative divider
//   request : i_valid/o_ready, i_op, i_a, i_b, i_tag
//   result  : o_valid/i_ready, o_result, o_tag (held until taken)
//   divider : o_div_valid pulse, o_div_a/o_div_b/o_div_signed, i_div_valid/i_div_quotient/i_div_remainder
//   optional: DIV_RESULT_CACHE_EN keeps the last divider result so a repeat of the
//             same operands (e.g. DIV then REM) skips the divider
import div_pkg::*;
module div_issue_ctrl #(
  parameter int TAG_W = 5,
  parameter int DIV_BLANK = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_div_valid,
  output logic [31:0]      o_div_a,
  output logic [31:0]      o_div_b,
  output logic             o_div_signed,
  input  logic             i_div_valid,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder
);
  localparam int CW = $clog2(DIV_BLANK + 2);
  state_t state;
  logic rem_sel;
  logic [CW-1:0] cnt;
  logic is_special;
  logic [31:0] special_result;
  div_special_case u_special (.op(i_op), .a(i_a), .b(i_b), .is_special(is_special), .special_result(special_result));
`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] c_a, c_b, c_q, c_r;
  logic c_s, c_ok, hit;
  assign hit = c_ok && c_a == i_a && c_b == i_b && c_s == !i_op[0];
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_div_valid <= 1'b0;
      o_result <= '0;
      o_tag <= '0;
      o_div_a <= '0;
      o_div_b <= '0;
      o_div_signed <= 1'b0;
      rem_sel <= 1'b0;
      cnt <= '0;
`ifdef DIV_RESULT_CACHE_EN
      c_a <= '0;
      c_b <= '0;
      c_q <= '0;
      c_r <= '0;
      c_s <= 1'b0;
      c_ok <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          o_tag <= i_tag;
          rem_sel <= i_op[1];
          o_ready <= 1'b0;
          if (is_special) begin
            o_result <= special_result;
            o_valid <= 1'b1;
            state <= RESP;
          end
`ifdef DIV_RESULT_CACHE_EN
          else if (hit) begin
            o_result <= i_op[1] ? c_r : c_q;
            o_valid <= 1'b1;
            state <= RESP;
          end
`endif
          else begin
            o_div_a <= i_a;
            o_div_b <= i_b;
            o_div_signed <= !i_op[0];
            o_div_valid <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          o_div_valid <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        // the divider's valid may still be high from its previous op for a few cycles
        WAIT: if (cnt != CW'(DIV_BLANK)) cnt <= cnt + 1'b1;
        else if (i_div_valid) begin
          o_result <= rem_sel ? i_div_remainder : i_div_quotient;
          o_valid <= 1'b1;
          state <= RESP;
`ifdef DIV_RESULT_CACHE_EN
          c_a <= o_div_a;
          c_b <= o_div_b;
          c_s <= o_div_signed;
          c_q <= i_div_quotient;
          c_r <= i_div_remainder;
          c_ok <= 1'b1;
`endif
        end
        RESP: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized self-checking bench with a divider stub and arithmetic reference model
module tb_div_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int DIV_BLANK = 2;
  logic clk = 1'b0;
  logic rst, i_valid, o_ready, o_valid, i_ready, o_div_valid, o_div_signed, i_div_valid;
  logic [1:0] i_op;
  logic [31:0] i_a, i_b, o_result, o_div_a, o_div_b, i_div_quotient, i_div_remainder;
  logic [TAG_W-1:0] i_tag, o_tag;
  int pass_cnt = 0, total = 0;
  int stub_d = 0;
  bit stub_en = 1'b1;
  bit m_ok = 1'b0;
  bit m_s;
  logic [31:0] m_a, m_b, sq, sr;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .DIV_BLANK(DIV_BLANK)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag),
    .o_div_valid(o_div_valid), .o_div_a(o_div_a), .o_div_b(o_div_b), .o_div_signed(o_div_signed),
    .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder)
  );

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  function automatic bit is_spec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // divider stub: stale (wrong) valid during the blank window, then the true result after stub_d idle cycles
  initial begin
    i_div_valid = 1'b0;
    i_div_quotient = '0;
    i_div_remainder = '0;
    forever begin
      @(negedge clk);
      if (o_div_valid && stub_en) begin
        sq = ref_div({1'b0, !o_div_signed}, o_div_a, o_div_b);
        sr = ref_div({1'b1, !o_div_signed}, o_div_a, o_div_b);
        i_div_valid = 1'b1;
        i_div_quotient = ~sq;
        i_div_remainder = ~sr;
        repeat (DIV_BLANK) @(negedge clk);
        @(negedge clk);
        if (stub_d > 0) begin
          i_div_valid = 1'b0;
          repeat (stub_d) @(negedge clk);
        end
        i_div_valid = 1'b1;
        i_div_quotient = sq;
        i_div_remainder = sr;
        for (int k = 0; k < 60 && !o_valid; k++) @(negedge clk);
        i_div_valid = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int d, input int hold);
    logic [31:0] exp;
    int exp_lat, lat, pulses;
    bit spec, hit;
    exp = ref_div(op, a, b);
    spec = is_spec(op, a, b);
    hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    hit = !spec && m_ok && m_a == a && m_b == b && m_s == !op[0];
`endif
    exp_lat = (spec || hit) ? 1 : DIV_BLANK + 3 + d;
    stub_d = d;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) $display("FAIL ready_idle got=%b want=1", o_ready); else pass_cnt++;
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = tag; i_ready = 1'b0;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 0;
    pulses = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      total++;
      if (o_ready !== 1'b0) $display("FAIL ready_busy cyc=%0d got=%b want=0", lat, o_ready); else pass_cnt++;
      if (o_div_valid === 1'b1) begin
        pulses++;
        total++;
        if ({o_div_a, o_div_b, o_div_signed} !== {a, b, !op[0]})
          $display("FAIL div_operands got=%h/%h/%b want=%h/%h/%b", o_div_a, o_div_b, o_div_signed, a, b, !op[0]);
        else pass_cnt++;
      end
      if (o_valid === 1'b1) break;
      if (lat >= 80) begin
        total++;
        $display("FAIL result_timeout got=no o_valid after %0d cycles want=o_valid", lat);
        break;
      end
    end
    total++;
    if (lat != exp_lat) $display("FAIL latency op=%0d got=%0d want=%0d", op, lat, exp_lat); else pass_cnt++;
    total++;
    if (o_result !== exp) $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", op, a, b, o_result, exp); else pass_cnt++;
    total++;
    if (o_tag !== tag) $display("FAIL tag got=%h want=%h", o_tag, tag); else pass_cnt++;
    total++;
    if (pulses != ((spec || hit) ? 0 : 1)) $display("FAIL issue_pulses got=%0d want=%0d", pulses, (spec || hit) ? 0 : 1); else pass_cnt++;
    if (!spec && !hit) begin
      m_ok = 1'b1; m_a = a; m_b = b; m_s = !op[0];
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_ready, o_result, o_tag} !== {1'b1, 1'b0, exp, tag})
        $display("FAIL hold_stable cyc=%0d got=%b/%b/%h/%h want=1/0/%h/%h", h, o_valid, o_ready, o_result, o_tag, exp, tag);
      else pass_cnt++;
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_ready} !== 2'b01) $display("FAIL handoff got=valid %b ready %b want=valid 0 ready 1", o_valid, o_ready); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_ready, o_valid, o_div_valid, o_result, o_tag, o_div_a, o_div_b, o_div_signed} !== {3'b100, 32'h0, 5'h0, 64'h0, 1'b0})
      $display("FAIL reset_state got=rdy %b vld %b dv %b res %h tag %h a %h b %h s %b want=1 0 0 zeros",
               o_ready, o_valid, o_div_valid, o_result, o_tag, o_div_a, o_div_b, o_div_signed);
    else pass_cnt++;
    rst = 1'b0;
    m_ok = 1'b0;
  endtask

  task automatic test_special();
    do_op(2'b00, 32'd7, 32'd0, 5'd1, 0, 0);
    do_op(2'b11, 32'd7, 32'd0, 5'd2, 0, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, 0);
    do_op(2'b10, 32'd9, 32'd0, 5'd5, 0, 0);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 0);
  endtask

  task automatic test_blank();
    do_op(2'b00, -32'sd7, 32'd3, 5'd7, 0, 0);
    do_op(2'b10, -32'sd7, 32'd3, 5'd8, 2, 0);
  endtask

  task automatic test_backpressure();
    do_op(2'b01, 32'd1000, 32'd10, 5'd9, 1, 5);
    do_op(2'b00, 32'd5, 32'd0, 5'd10, 0, 3);
  endtask

  task automatic test_cache();
    do_op(2'b01, 32'd100, 32'd7, 5'd11, 0, 0);
    do_op(2'b11, 32'd100, 32'd7, 5'd12, 0, 0);
  endtask

  task automatic test_reset_mid();
    stub_en = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_op = 2'b00; i_a = 32'd1000; i_b = 32'd9; i_tag = 5'd13;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_ready, o_valid} !== 2'b00) $display("FAIL wait_state got=rdy %b vld %b want=0 0", o_ready, o_valid); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ok = 1'b0;
    @(negedge clk);
    total++;
    if ({o_ready, o_valid, o_div_valid, o_result} !== {3'b100, 32'h0})
      $display("FAIL reset_mid got=rdy %b vld %b dv %b res %h want=1 0 0 0", o_ready, o_valid, o_div_valid, o_result);
    else pass_cnt++;
    i_div_valid = 1'b1; i_div_quotient = 32'd123; i_div_remainder = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_ready} !== 2'b01) $display("FAIL late_result cyc=%0d got=vld %b rdy %b want=0 1", k, o_valid, o_ready); else pass_cnt++;
    end
    i_div_valid = 1'b0;
    stub_en = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, pa, pb;
    int sel;
    pa = 32'd55; pb = 32'd6;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 0;
      else if (sel == 1) begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
      else if (sel == 2) b = $urandom_range(1, 20);
      else if (sel == 3) begin a = pa; b = pb; end
      pa = a; pb = b;
      do_op(2'($urandom), a, b, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=no finish want=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_op = '0; i_a = '0; i_b = '0; i_tag = '0;
    test_reset();
    test_special();
    test_blank();
    test_backpressure();
    test_cache();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
